vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Single-port owner of the 40x30 text-mode VRAM (11-bit cells: color[10:8], char[7:0]).
- Shares the RAM between three requesters:
  - the VGA scanner's read strobe, which must never stall;
  - a CPU load/store port with a req/ack handshake;
  - a hardware clear-screen sequencer that fills every cell with one value.
- Sits between the CPU bus glue, the VGA text pipeline and an external asynchronous-read (distributed) RAM.

Parameters:
- CELLS, 1200, number of valid cells (40 cols x 30 rows).
- AW, 11, VRAM address width.
- DW, 11, VRAM cell width.
- COLS, 40, characters per row (cursor feature only).
- ROWS, 30, character rows (cursor feature only).

Ports:
- vga_clk in 1: sole clock, rising edge.
- rst in 1: asynchronous, active-low reset.
- vga_rdn in 1: scanner read strobe, active-low.
- vga_addr in AW: scanner cell address.
- vram_out out DW: scanner read data; combinational copy of ram_dout.
- cpu_req in 1: CPU request; held high with cpu_we/cpu_addr/cpu_wdata stable until cpu_ack.
- cpu_we in 1: 1 = write, 0 = read.
- cpu_addr in AW: CPU cell address.
- cpu_wdata in DW: CPU write data.
- cpu_ack out 1: one-cycle completion pulse.
- cpu_rdata out DW: read data; valid while cpu_ack = 1, then held.
- clr_start in 1: one-cycle pulse that starts the clear.
- clr_data in DW: fill value; sampled on the accepted clr_start.
- clr_busy out 1: high while the clear is in progress.
- ram_addr out AW: RAM address.
- ram_we out 1: RAM write enable.
- ram_din out DW: RAM write data.
- ram_dout in DW: RAM asynchronous read data.

Behaviour:
- Reset values: all FSM state IDLE; cpu_ack = 0, cpu_rdata = 0, clr_busy = 0, internal clear address = 0, latched fill = 0.
- RAM port priority per cycle (ram_addr/ram_we/ram_din are combinational):
  1. vga_rdn = 0: ram_addr = vga_addr, ram_we = 0.
  2. Otherwise, state CLEAR: ram_addr = clr_addr, ram_we = 1, ram_din = latched fill.
  3. Otherwise, state IDLE with cpu_req = 1: ram_addr = cpu_addr, ram_we = cpu_we AND (cpu_addr < CELLS).
  4. Otherwise: ram_we = 0, ram_addr = 0.
- Scanner service:
  - vram_out = ram_dout at all times.
  - The scanner samples it in the same cycle its strobe is low; zero added latency; never stalled.
- FSM states:
  - IDLE:
    - clr_start = 1 -> CLEAR. Latch clr_data, clr_addr = 0. Has priority over a simultaneous cpu_req.
    - Else, cpu_req = 1 and vga_rdn = 1 -> access performed this cycle; capture cpu_rdata (ram_dout, or 0 if cpu_addr >= CELLS); -> CPU_ACK.
    - A cpu_req in a cycle with vga_rdn = 0 waits in IDLE.
  - CPU_ACK:
    - cpu_ack = 1 for exactly this cycle; cpu_req is ignored; -> IDLE.
    - The requester drops cpu_req in this cycle; a request still high in IDLE afterwards is a new access.
  - CLEAR:
    - clr_busy = 1.
    - Each cycle with vga_rdn = 1: write, then clr_addr += 1.
    - Cycles with vga_rdn = 0: clr_addr holds.
    - After writing cell CELLS-1 -> IDLE; clr_busy falls the next cycle. Total = CELLS write cycles plus scanner-stolen cycles.
    - clr_start while in CLEAR is ignored.
    - cpu_req while in CLEAR waits; no ack.
- Latency:
  - CPU access with no contention: req seen in IDLE at cycle N -> cpu_ack at N+1.
  - Scanner stalls the CPU by at most 1 cycle, since the strobe is low 1 in 8 pixels.
- Out-of-range address (cpu_addr >= CELLS): write suppressed, read returns 0, ack still issued.
- Reset mid-operation: FSM aborts to IDLE; RAM contents are partially written and not restored; pending CPU request is dropped.

Optional Feature:
- Macro: VRAM_CURSOR_ADV_EN.
- Defined:
  - Adds output cursor, 13 bits: [12] = 0, [11:6] = row, [5:0] = col.
  - Each acknowledged in-range CPU write advances col by 1.
  - col wraps COLS-1 -> 0 and increments row; row wraps ROWS-1 -> 0.
  - Reset and clear completion set cursor to 0.
  - Reads do not move the cursor.
- Undefined: no cursor port and no cursor logic.

Decomposition:
- Shared package vram_pkg:
  - widths AW, DW and constants CELLS, COLS, ROWS;
  - FSM state encoding IDLE/CPU_ACK/CLEAR, 2 bits.
- One natural sub-module: vram_clear_seq, holding the clear address counter, latched fill value and done flag.
- Priority mux and handshake FSM stay in vram_arbiter.

Test Plan:
- Reset low then release, no requests -> cpu_ack = 0, clr_busy = 0, ram_we = 0, cpu_rdata = 0.
- CPU write addr 5 data 0x741, vga_rdn = 1; then read addr 5 -> write ack 1 cycle after req; read ack returns cpu_rdata = 0x741; no double-ack while req stays high through CPU_ACK.
- cpu_req on a cycle with vga_rdn = 0 -> ram_addr = vga_addr, ram_we = 0, no ack that cycle; ack one cycle later than uncontended.
- clr_start with fill 0x720 while scanner strobes every 8th cycle -> all 1200 cells = 0x720; clr_busy high exactly 1200 + stolen cycles; a cpu_req raised during the clear is acked only after clr_busy falls.
- clr_start and cpu_req in the same IDLE cycle -> clear wins. Then write addr 1300 -> ram_we = 0, ack issued; read addr 1300 -> cpu_rdata = 0.
- With VRAM_CURSOR_ADV_EN: 41 writes after reset -> cursor = {0, row 1, col 1}; reset asserted mid-clear -> clr_busy = 0 immediately, cursor = 0.

Source files
------------

// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vram_pkg
// Brief    : Shared widths, geometry and FSM encoding for the VRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package vram_pkg;

    localparam int AW    = 11;
    localparam int DW    = 11;
    localparam int CELLS = 1200;
    localparam int COLS  = 40;
    localparam int ROWS  = 30;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACK = 2'd1,
        CLEAR   = 2'd2
    } state_t;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return addr < AW'(CELLS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter_if
// Brief    : CPU load/store req/ack bus into the VRAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface vram_arbiter_if;
    import vram_pkg::*;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata
    );

endinterface
`default_nettype wire

// File: rtl/vram_clear_seq.sv
`default_nettype none
// ============================================================================
// Module   : vram_clear_seq
// Brief    : Clear-screen address walker and latched fill value.
// Revision : 1.0 - initial release
// ============================================================================
module vram_clear_seq
    import vram_pkg::*;
(
    input  wire           vga_clk,
    input  wire           rst,
    input  wire           i_start,
    input  wire           i_step,
    input  wire [DW-1:0]  i_fill,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_fill,
    output logic          o_done
);

    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_fill;
    logic          w_last;

    assign w_last = (r_addr == AW'(CELLS - 1));
    assign o_done = i_step && w_last;
    assign o_addr = r_addr;
    assign o_fill = r_fill;

    // Address parks at 0 after the last cell so an idle walker reads as fresh.
    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
            r_fill <= '0;
        end else if (i_start) begin
            r_addr <= '0;
            r_fill <= i_fill;
        end else if (i_step) begin
            r_addr <= w_last ? '0 : r_addr + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_arbiter
// Brief    : Single-port VRAM owner: scanner > clear > CPU. Optional cursor
//            auto-advance on CPU writes via VRAM_CURSOR_ADV_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vram_arbiter
    import vram_pkg::*;
(
    input  wire            vga_clk,
    input  wire            rst,
    input  wire            vga_rdn,
    input  wire  [AW-1:0]  vga_addr,
    output logic [DW-1:0]  vram_out,
    vram_arbiter_if.slave  cpu_bus,
    input  wire            clr_start,
    input  wire  [DW-1:0]  clr_data,
    output logic           clr_busy,
    output logic [AW-1:0]  ram_addr,
    output logic           ram_we,
    output logic [DW-1:0]  ram_din,
    input  wire  [DW-1:0]  ram_dout
`ifdef VRAM_CURSOR_ADV_EN
    ,
    output logic [12:0]    cursor
`endif
);

    state_t        r_state;
    logic          r_cpu_ack;
    logic [DW-1:0] r_cpu_rdata;
    logic          r_clr_busy;

    logic          w_cpu_in_range;
    logic          w_cpu_go;
    logic          w_clr_go;
    logic          w_clr_step;
    logic          w_clr_done;
    logic [AW-1:0] w_clr_addr;
    logic [DW-1:0] w_clr_fill;

    assign w_cpu_in_range = in_range(cpu_bus.cpu_addr);
    assign w_clr_go       = (r_state == IDLE) && clr_start;
    assign w_cpu_go       = (r_state == IDLE) && !clr_start && cpu_bus.cpu_req && vga_rdn;
    assign w_clr_step     = (r_state == CLEAR) && vga_rdn;

    vram_clear_seq u_clear_seq (
        .vga_clk (vga_clk),
        .rst     (rst),
        .i_start (w_clr_go),
        .i_step  (w_clr_step),
        .i_fill  (clr_data),
        .o_addr  (w_clr_addr),
        .o_fill  (w_clr_fill),
        .o_done  (w_clr_done)
    );

    // The scanner strobe always owns the port so pixel fetch never stalls.
    always_comb begin
        ram_addr = '0;
        ram_we   = 1'b0;
        ram_din  = cpu_bus.cpu_wdata;
        if (!vga_rdn) begin
            ram_addr = vga_addr;
        end else if (r_state == CLEAR) begin
            ram_addr = w_clr_addr;
            ram_we   = 1'b1;
            ram_din  = w_clr_fill;
        end else if ((r_state == IDLE) && cpu_bus.cpu_req) begin
            ram_addr = cpu_bus.cpu_addr;
            ram_we   = cpu_bus.cpu_we && w_cpu_in_range;
        end
    end

    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_clr_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_clr_go) begin
                        r_state    <= CLEAR;
                        r_clr_busy <= 1'b1;
                    end else if (w_cpu_go) begin
                        r_state     <= CPU_ACK;
                        r_cpu_ack   <= 1'b1;
                        r_cpu_rdata <= w_cpu_in_range ? ram_dout : '0;
                    end
                end
                CPU_ACK: begin
                    r_state   <= IDLE;
                    r_cpu_ack <= 1'b0;
                end
                CLEAR: begin
                    if (w_clr_done) begin
                        r_state    <= IDLE;
                        r_clr_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_cpu_ack  <= 1'b0;
                    r_clr_busy <= 1'b0;
                end
            endcase
        end
    end

    assign vram_out          = ram_dout;
    assign cpu_bus.cpu_ack   = r_cpu_ack;
    assign cpu_bus.cpu_rdata = r_cpu_rdata;
    assign clr_busy          = r_clr_busy;

`ifdef VRAM_CURSOR_ADV_EN
    logic [5:0] r_row;
    logic [5:0] r_col;

    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_clr_done) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_cpu_go && cpu_bus.cpu_we && w_cpu_in_range) begin
            if (r_col == 6'(COLS - 1)) begin
                r_col <= '0;
                r_row <= (r_row == 6'(ROWS - 1)) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign cursor = {1'b0, r_row, r_col};
`endif

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_arbiter
// Brief    : Directed bench with a cycle-level reference model of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;
    import vram_pkg::*;

    logic          vga_clk = 1'b0;
    logic          rst;
    logic          vga_rdn;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] vram_out;
    logic          clr_start;
    logic [DW-1:0] clr_data;
    logic          clr_busy;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
`ifdef VRAM_CURSOR_ADV_EN
    logic [12:0]   cursor;
`endif

    vram_arbiter_if cpu_bus ();

    always #5 vga_clk = ~vga_clk;

    vram_arbiter dut (
        .vga_clk   (vga_clk),
        .rst       (rst),
        .vga_rdn   (vga_rdn),
        .vga_addr  (vga_addr),
        .vram_out  (vram_out),
        .cpu_bus   (cpu_bus),
        .clr_start (clr_start),
        .clr_data  (clr_data),
        .clr_busy  (clr_busy),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
`ifdef VRAM_CURSOR_ADV_EN
        ,
        .cursor    (cursor)
`endif
    );

    // External distributed RAM: asynchronous read, synchronous write.
    logic [DW-1:0] ram [0:2047];
    assign ram_dout = ram[ram_addr];
    always @(posedge vga_clk) if (ram_we) ram[ram_addr] <= ram_din;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: screen contents, clear progress and pending ack.
    int gold [0:CELLS-1];
    bit m_busy   = 0;
    bit m_ack    = 0;
    int m_left   = 0;
    int m_fill   = 0;
    int m_rdata  = 0;
    int m_writes = 0;

    always @(negedge vga_clk) begin
        int e_addr, e_we, e_din, a, pos;
        if (!rst) begin
            m_busy = 0; m_ack = 0; m_left = 0; m_fill = 0; m_rdata = 0; m_writes = 0;
        end
        a = int'(cpu_bus.cpu_addr);
        e_addr = 0; e_we = 0; e_din = 0;
        if (!vga_rdn) begin
            e_addr = int'(vga_addr);
        end else if (m_busy) begin
            e_addr = CELLS - m_left; e_we = 1; e_din = m_fill;
        end else if (!m_ack && cpu_bus.cpu_req) begin
            e_addr = a; e_we = (cpu_bus.cpu_we && a < CELLS) ? 1 : 0; e_din = int'(cpu_bus.cpu_wdata);
        end
        chk("cpu_ack",   int'(cpu_bus.cpu_ack),   int'(m_ack));
        chk("clr_busy",  int'(clr_busy),          int'(m_busy));
        chk("cpu_rdata", int'(cpu_bus.cpu_rdata), m_rdata);
        chk("ram_we",    int'(ram_we),            e_we);
        chk("ram_addr",  int'(ram_addr),          e_addr);
        if (e_we != 0) chk("ram_din", int'(ram_din), e_din);
        chk("vram_out",  int'(vram_out),          int'(ram[ram_addr]));
`ifdef VRAM_CURSOR_ADV_EN
        pos = m_writes % CELLS;
        chk("cursor", int'(cursor), (pos / COLS) * 64 + (pos % COLS));
`else
        pos = 0;
`endif
        if (rst) begin
            if (m_busy) begin
                if (vga_rdn) begin
                    gold[CELLS - m_left] = m_fill;
                    m_left--;
                    if (m_left == 0) begin m_busy = 0; m_writes = 0; end
                end
            end else if (m_ack) begin
                m_ack = 0;
            end else begin
                if (cpu_bus.cpu_req && vga_rdn && !clr_start) begin
                    m_ack   = 1;
                    m_rdata = (a < CELLS) ? gold[a] : 0;
                    if (cpu_bus.cpu_we && a < CELLS) m_writes++;
                end
                if (cpu_bus.cpu_req && vga_rdn && cpu_bus.cpu_we && a < CELLS)
                    gold[a] = int'(cpu_bus.cpu_wdata);
                if (clr_start) begin
                    m_busy = 1; m_left = CELLS; m_fill = int'(clr_data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    // One CPU transaction; lat counts cycles from the request cycle to the ack.
    task automatic cpu_op(input bit we, input int addr, input int data, input bit contend,
                          input bit with_clr, output int rdata, output int lat);
        bit got;
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = we;
        cpu_bus.cpu_addr  = AW'(addr);
        cpu_bus.cpu_wdata = DW'(data);
        if (contend) begin vga_rdn = 1'b0; vga_addr = 11'd7; end
        if (with_clr) begin clr_start = 1'b1; clr_data = '0; end
        lat = 0; got = 0; rdata = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge vga_clk);
            if (cpu_bus.cpu_ack) begin got = 1; rdata = int'(cpu_bus.cpu_rdata); break; end
            tick();
            vga_rdn = 1'b1; clr_start = 1'b0;
            lat++;
        end
        if (!got) begin
            n_vec++; n_fail++;
            $display("FAIL cpu_ack timeout: got no ack, expected one within 4000 cycles");
        end
        tick();
        cpu_bus.cpu_req = 1'b0;
    endtask

    initial begin
        int rd, lat, busy_cnt, stolen, early_ack, ack_rd, bad;
        bit done;
        for (int i = 0; i < 2048; i++) ram[i] = '0;
        for (int i = 0; i < CELLS; i++) gold[i] = 0;
        rst = 1'b1; vga_rdn = 1'b1; vga_addr = '0; clr_start = 1'b0; clr_data = '0;
        cpu_bus.cpu_req = 1'b0; cpu_bus.cpu_we = 1'b0;
        cpu_bus.cpu_addr = '0; cpu_bus.cpu_wdata = '0;
        #1 rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        @(negedge vga_clk);
        chk("reset cpu_ack",   int'(cpu_bus.cpu_ack),   0);
        chk("reset clr_busy",  int'(clr_busy),          0);
        chk("reset ram_we",    int'(ram_we),            0);
        chk("reset cpu_rdata", int'(cpu_bus.cpu_rdata), 0);
        tick();

        cpu_op(1'b1, 5, 'h741, 1'b0, 1'b0, rd, lat);
        chk("write latency", lat, 1);
        cpu_op(1'b0, 5, 0, 1'b0, 1'b0, rd, lat);
        chk("read back 5", rd, 'h741);
        chk("read latency", lat, 1);
        cpu_op(1'b0, 5, 0, 1'b1, 1'b0, rd, lat);
        chk("contended latency", lat, 2);
        chk("contended read 5", rd, 'h741);

        // Clear with the scanner stealing every 8th cycle and a CPU read arriving mid-clear.
        clr_data = 11'h720; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        busy_cnt = 0; stolen = 0; early_ack = 0; ack_rd = -1; done = 0;
        for (int c = 0; c < 4000 && !done; c++) begin
            vga_rdn  = (c % 8 != 7);
            vga_addr = AW'(c % CELLS);
            if (c == 100) begin
                cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = 11'd10;
            end
            @(negedge vga_clk);
            if (clr_busy) begin
                busy_cnt++;
                if (!vga_rdn) stolen++;
                if (cpu_bus.cpu_ack) early_ack = 1;
            end
            if (cpu_bus.cpu_ack) begin ack_rd = int'(cpu_bus.cpu_rdata); done = 1; end
            tick();
        end
        cpu_bus.cpu_req = 1'b0; vga_rdn = 1'b1;
        chk("clear busy cycles", busy_cnt, CELLS + stolen);
        chk("ack during clear", early_ack, 0);
        chk("read after clear", ack_rd, 'h720);
        bad = 0;
        for (int i = 0; i < CELLS; i++) if (ram[i] != 11'h720) bad++;
        chk("cells not filled", bad, 0);
        tick();

        // Clear wins over a same-cycle write; the write completes after the clear.
        cpu_op(1'b1, 20, 'h155, 1'b0, 1'b1, rd, lat);
        chk("clear-wins latency", lat, CELLS + 2);
        chk("cell 0 after clear", int'(ram[0]), 0);
        cpu_op(1'b0, 20, 0, 1'b0, 1'b0, rd, lat);
        chk("read back 20", rd, 'h155);
        cpu_op(1'b1, 1300, 'h3ff, 1'b0, 1'b0, rd, lat);
        chk("oob write latency", lat, 1);
        chk("oob write no ram", int'(ram[1300]), 0);
        cpu_op(1'b0, 1300, 0, 1'b0, 1'b0, rd, lat);
        chk("oob read data", rd, 0);

        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 41; i++) cpu_op(1'b1, 200 + i, 'h100 + i, 1'b0, 1'b0, rd, lat);
        @(negedge vga_clk);
`ifdef VRAM_CURSOR_ADV_EN
        chk("cursor after 41 writes", int'(cursor), 'h041);
`endif
        chk("cell 240", int'(ram[240]), 'h128);
        tick();

        clr_data = 11'h0aa; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        repeat (50) tick();
        rst = 1'b0;
        @(negedge vga_clk);
        chk("reset mid-clear busy", int'(clr_busy), 0);
        chk("partial clear cell 10", int'(ram[10]), 'h0aa);
`ifdef VRAM_CURSOR_ADV_EN
        chk("reset mid-clear cursor", int'(cursor), 0);
`endif
        tick();
        rst = 1'b1;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 1000000");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
